hack_data_memory: RTL and testbench

//   Responder side of the Hack CPU data-memory interface (addressM/outM/writeM -> inM).

---
 rtl/hack_data_memory_if.sv | 33 +++
 rtl/hack_data_memory.sv | 105 ++++++++++
 tb/tb_hack_data_memory.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hack_data_memory_if.sv
// Hack CPU data-memory bus plus keyboard and screen-FIFO side channels.
// The memory block uses the slave view; the CPU/peripheral side uses the master view.
interface hack_data_memory_if #(
  parameter int SCREEN_WORDS = 8192,
  parameter int FIFO_DEPTH   = 8
);
  localparam int SCR_AW = $clog2(SCREEN_WORDS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  logic [15:0]       addressM;
  logic [15:0]       outM;
  logic              writeM;
  logic [15:0]       inM;
  logic [15:0]       kbd_code;
  logic              kbd_valid;
  logic              kbd_ready;
  logic [SCR_AW-1:0] scr_addr;
  logic [15:0]       scr_data;
  logic              scr_valid;
  logic              scr_ready;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_overflow;

  modport master (
    output addressM, outM, writeM, kbd_code, kbd_valid, scr_ready,
    input  inM, kbd_ready, scr_addr, scr_data, scr_valid, fifo_count, fifo_overflow
  );

  modport slave (
    input  addressM, outM, writeM, kbd_code, kbd_valid, scr_ready,
    output inM, kbd_ready, scr_addr, scr_data, scr_valid, fifo_count, fifo_overflow
  );
endinterface

// File: rtl/hack_data_memory.sv
// Hack data memory responder: RAM, screen shadow with write-forwarding FIFO,
// and the keyboard register, all behind a zero-latency read path.
module hack_data_memory #(
  parameter int          RAM_WORDS    = 16384,
  parameter int          SCREEN_WORDS = 8192,
  parameter logic [15:0] KBD_ADDR     = 16'h6000,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic          CLK,
  input  logic          reset,
  hack_data_memory_if.slave bus
);
  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCREEN_WORDS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0] SCR_BASE = 16'(RAM_WORDS);
  localparam logic [15:0] SCR_END  = 16'(RAM_WORDS + SCREEN_WORDS);

  logic [15:0]       ram     [RAM_WORDS];
  logic [15:0]       scr_mem [SCREEN_WORDS];
  logic [SCR_AW-1:0] q_addr  [FIFO_DEPTH];
  logic [15:0]       q_data  [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic [15:0]       key;

  logic              is_ram;
  logic              is_scr;
  logic              is_kbd;
  logic [RAM_AW-1:0] ram_idx;
  logic [SCR_AW-1:0] scr_idx;
  logic              full;
  logic              push_req;
  logic              push;
  logic              pop;

  assign is_ram  = bus.addressM < SCR_BASE;
  assign is_scr  = (bus.addressM >= SCR_BASE) && (bus.addressM < SCR_END);
  assign is_kbd  = bus.addressM == KBD_ADDR;
  assign ram_idx = bus.addressM[RAM_AW-1:0];
  assign scr_idx = bus.addressM[SCR_AW-1:0];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign full     = count == CNT_W'(FIFO_DEPTH);
  assign pop      = (count != '0) && bus.scr_ready;
  assign push_req = bus.writeM && is_scr;
  assign push     = push_req && (!full || pop);

  // Reads see the array contents before this edge's write, giving old-value semantics.
  always_comb begin
    bus.inM = '0;
    if (is_ram)
      bus.inM = ram[ram_idx];
    else if (is_scr)
      bus.inM = scr_mem[scr_idx];
    else if (is_kbd)
      bus.inM = key;
  end

  always_ff @(posedge CLK) begin
    if (bus.writeM && is_ram)
      ram[ram_idx] <= bus.outM;
    if (push_req)
      scr_mem[scr_idx] <= bus.outM;
    if (push) begin
      q_addr[wr_ptr] <= scr_idx;
      q_data[wr_ptr] <= bus.outM;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      key      <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push_req && !push)
        overflow <= 1'b1;
      if (bus.kbd_valid && bus.kbd_ready)
        key <= bus.kbd_code;
    end
  end

  assign bus.kbd_ready     = !reset;
  assign bus.scr_valid     = count != '0;
  assign bus.scr_addr      = q_addr[rd_ptr];
  assign bus.scr_data      = q_data[rd_ptr];
  assign bus.fifo_count    = count;
  assign bus.fifo_overflow = overflow;
endmodule

// File: tb/tb_hack_data_memory.sv
// Bench for hack_data_memory: directed scenarios plus a randomized run
// compared against an array/queue model of the memory map.
module tb_hack_data_memory;
  localparam int DEPTH = 8;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  hack_data_memory_if #(.SCREEN_WORDS(8192), .FIFO_DEPTH(DEPTH)) bus ();

  hack_data_memory #(
    .RAM_WORDS(16384), .SCREEN_WORDS(8192), .KBD_ADDR(16'h6000), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .bus(bus.slave)
  );

  logic [15:0] ram_m [16384];
  bit          ram_w [16384];
  logic [15:0] scr_m [8192];
  bit          scr_w [8192];
  logic [15:0] key_m;
  bit          ovf_m;
  logic [28:0] q_m [$];
  int          n_checks = 0;
  int          n_fail = 0;

  // {known, value} expected on inM for a read of address a.
  function automatic logic [16:0] exp_rd(input logic [15:0] a);
    if (a < 16'h4000) return {ram_w[a[13:0]] ? 1'b1 : 1'b0, ram_m[a[13:0]]};
    if (a < 16'h6000) return {scr_w[a[12:0]] ? 1'b1 : 1'b0, scr_m[a[12:0]]};
    if (a == 16'h6000) return {1'b1, key_m};
    return {1'b1, 16'h0000};
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic w,
                       input logic [15:0] kc, input logic kv, input logic sr);
    bus.addressM  = a;
    bus.outM      = d;
    bus.writeM    = w;
    bus.kbd_code  = kc;
    bus.kbd_valid = kv;
    bus.scr_ready = sr;
  endtask

  // Advance one clock and apply the memory-map rules to the model.
  task automatic tick();
    logic r, w, kv, sr;
    logic [15:0] a, d, kc;
    r = reset; w = bus.writeM; kv = bus.kbd_valid; sr = bus.scr_ready;
    a = bus.addressM; d = bus.outM; kc = bus.kbd_code;
    @(posedge CLK);
    #1;
    if (r) begin
      q_m.delete();
      ovf_m = 1'b0;
      key_m = 16'h0;
    end else begin
      if (q_m.size() > 0 && sr) void'(q_m.pop_front());
      if (w && a < 16'h4000) begin
        ram_m[a[13:0]] = d;
        ram_w[a[13:0]] = 1'b1;
      end else if (w && a < 16'h6000) begin
        scr_m[a[12:0]] = d;
        scr_w[a[12:0]] = 1'b1;
        if (q_m.size() < DEPTH) q_m.push_back({a[12:0], d});
        else ovf_m = 1'b1;
      end
      if (kv) key_m = kc;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(16'h7000, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(16'h6000, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.kbd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_kbd_ready got=%0h exp=0", bus.kbd_ready); end
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.scr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_scr_valid got=%0h exp=0", bus.scr_valid); end
    n_checks++;
    if (bus.fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_fifo_count got=%0d exp=0", bus.fifo_count); end
    n_checks++;
    if (bus.fifo_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%0h exp=0", bus.fifo_overflow); end
    n_checks++;
    if (bus.inM !== 16'h0000) begin n_fail++; $display("FAIL reset_kbd_read got=%h exp=0000", bus.inM); end
    n_checks++;
    if (bus.kbd_ready !== 1'b1) begin n_fail++; $display("FAIL kbd_ready_after_reset got=%0h exp=1", bus.kbd_ready); end
  endtask

  task automatic test_ram();
    logic [15:0] a, d;
    drive(16'h0010, 16'hAAAA, 1'b1, 16'h0, 1'b0, 1'b0);
    tick();
    drive(16'h0010, 16'h1234, 1'b1, 16'h0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.inM !== 16'hAAAA) begin n_fail++; $display("FAIL ram_old_value_in_write got=%h exp=AAAA", bus.inM); end
    tick();
    drive(16'h0010, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.inM !== 16'h1234) begin n_fail++; $display("FAIL ram_readback got=%h exp=1234", bus.inM); end
    tick();
    for (int i = 0; i < 12; i++) begin
      a = (i == 0) ? 16'h3FFF : 16'($urandom_range(32, 16'h3FFF));
      d = 16'($urandom);
      drive(a, d, 1'b1, 16'h0, 1'b0, 1'b1);
      tick();
      drive(a, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
      #1;
      n_checks++;
      if (bus.inM !== d) begin n_fail++; $display("FAIL ram_random addr=%h got=%h exp=%h", a, bus.inM, d); end
      tick();
    end
  endtask

  task automatic test_screen_single();
    do_reset();
    drive(16'h4005, 16'hFFFF, 1'b1, 16'h0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.scr_valid !== 1'b0) begin n_fail++; $display("FAIL scr_no_bypass got=%0h exp=0", bus.scr_valid); end
    tick();
    drive(16'h4005, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({bus.scr_valid, bus.scr_addr, bus.scr_data} !== {1'b1, 13'h0005, 16'hFFFF}) begin
      n_fail++;
      $display("FAIL scr_head got=v%0h a=%h d=%h exp=v1 a=0005 d=FFFF", bus.scr_valid, bus.scr_addr, bus.scr_data);
    end
    n_checks++;
    if (bus.fifo_count !== 4'd1) begin n_fail++; $display("FAIL scr_count got=%0d exp=1", bus.fifo_count); end
    n_checks++;
    if (bus.inM !== 16'hFFFF) begin n_fail++; $display("FAIL scr_readback got=%h exp=FFFF", bus.inM); end
    tick();
  endtask

  task automatic test_overflow();
    logic [28:0] exp_l [$];
    logic [12:0] off;
    logic [15:0] d;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      off = (i == 8) ? 13'h1FFF : 13'(i * 3 + 1);
      d = 16'($urandom);
      if (i < 8) exp_l.push_back({off, d});
      drive(16'h4000 + {3'b000, off}, d, 1'b1, 16'h0, 1'b0, 1'b0);
      tick();
    end
    drive(16'h7000, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.fifo_count !== 4'd8) begin n_fail++; $display("FAIL ovf_count got=%0d exp=8", bus.fifo_count); end
    n_checks++;
    if (bus.fifo_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%0h exp=1", bus.fifo_overflow); end
    n_checks++;
    if (bus.inM !== 16'h0000) begin n_fail++; $display("FAIL unmapped_read got=%h exp=0000", bus.inM); end
    for (int i = 0; i < 8; i++) begin
      drive(16'h7000, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
      #1;
      n_checks++;
      if ({bus.scr_valid, bus.scr_addr, bus.scr_data} !== {1'b1, exp_l[i]}) begin
        n_fail++;
        $display("FAIL ovf_drain_%0d got=v%0h %h exp=v1 %h", i, bus.scr_valid, {bus.scr_addr, bus.scr_data}, exp_l[i]);
      end
      tick();
    end
    #1;
    n_checks++;
    if ({bus.scr_valid, bus.fifo_count, bus.fifo_overflow} !== {1'b0, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_after_drain got=v%0h c%0d o%0h exp=v0 c0 o1", bus.scr_valid, bus.fifo_count, bus.fifo_overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [28:0] exp_l [$];
    logic [12:0] off;
    logic [15:0] d;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      off = 13'($urandom_range(0, 8191));
      d = 16'($urandom);
      exp_l.push_back({off, d});
      drive(16'h4000 + {3'b000, off}, d, 1'b1, 16'h0, 1'b0, i == 8);
      tick();
    end
    drive(16'h7000, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.fifo_count !== 4'd8) begin n_fail++; $display("FAIL fullpp_count got=%0d exp=8", bus.fifo_count); end
    n_checks++;
    if (bus.fifo_overflow !== 1'b0) begin n_fail++; $display("FAIL fullpp_overflow got=%0h exp=0", bus.fifo_overflow); end
    for (int i = 1; i < 9; i++) begin
      drive(16'h7000, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
      #1;
      n_checks++;
      if ({bus.scr_valid, bus.scr_addr, bus.scr_data} !== {1'b1, exp_l[i]}) begin
        n_fail++;
        $display("FAIL fullpp_drain_%0d got=v%0h %h exp=v1 %h", i, bus.scr_valid, {bus.scr_addr, bus.scr_data}, exp_l[i]);
      end
      tick();
    end
  endtask

  task automatic test_keyboard();
    do_reset();
    drive(16'h6000, 16'h0, 1'b0, 16'h0041, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (bus.inM !== 16'h0000) begin n_fail++; $display("FAIL kbd_same_cycle got=%h exp=0000", bus.inM); end
    tick();
    drive(16'h6000, 16'h5555, 1'b1, 16'h0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.inM !== 16'h0041) begin n_fail++; $display("FAIL kbd_load got=%h exp=0041", bus.inM); end
    tick();
    drive(16'h6000, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (bus.inM !== 16'h0041) begin n_fail++; $display("FAIL kbd_write_ignored got=%h exp=0041", bus.inM); end
    tick();
    #1;
    n_checks++;
    if (bus.inM !== 16'h0000) begin n_fail++; $display("FAIL kbd_release got=%h exp=0000", bus.inM); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    drive(16'h0010, 16'h1234, 1'b1, 16'h0077, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(16'h4100 + 16'(i), 16'($urandom), 1'b1, 16'h0, 1'b0, 1'b0);
      tick();
    end
    drive(16'h7000, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.fifo_count !== 4'd3) begin n_fail++; $display("FAIL mid_count_before got=%0d exp=3", bus.fifo_count); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.inM !== 16'h0000) begin n_fail++; $display("FAIL mid_unmapped_in_reset got=%h exp=0000", bus.inM); end
    tick();
    reset = 1'b0;
    drive(16'h6000, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({bus.scr_valid, bus.fifo_count, bus.inM} !== {1'b0, 4'd0, 16'h0000}) begin
      n_fail++;
      $display("FAIL mid_after_reset got=v%0h c%0d kbd=%h exp=v0 c0 kbd=0000", bus.scr_valid, bus.fifo_count, bus.inM);
    end
    drive(16'h0010, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.inM !== 16'h1234) begin n_fail++; $display("FAIL mid_ram_kept got=%h exp=1234", bus.inM); end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] a, d, kc;
    logic w, kv, sr;
    logic [16:0] e;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: a = 16'($urandom_range(0, 63));
        1: a = 16'h4000 + 16'($urandom_range(0, 31));
        2: a = ($urandom_range(0, 1) == 0) ? 16'h3FFF : 16'h5FFF;
        3: a = 16'h6000;
        default: a = 16'($urandom_range(16'h6001, 16'hFFFF));
      endcase
      d  = 16'($urandom);
      w  = $urandom_range(0, 1) == 1;
      kv = $urandom_range(0, 4) == 0;
      kc = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
      sr = ((i / 50) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      drive(a, d, w, kc, kv, sr);
      #1;
      e = exp_rd(a);
      if (e[16]) begin
        n_checks++;
        if (bus.inM !== e[15:0]) begin n_fail++; $display("FAIL rnd_inM cyc=%0d addr=%h got=%h exp=%h", i, a, bus.inM, e[15:0]); end
      end
      n_checks++;
      if (bus.fifo_count !== 4'(q_m.size())) begin n_fail++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, bus.fifo_count, q_m.size()); end
      n_checks++;
      if (bus.scr_valid !== (q_m.size() != 0)) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%0h exp=%0h", i, bus.scr_valid, q_m.size() != 0); end
      if (q_m.size() != 0) begin
        n_checks++;
        if ({bus.scr_addr, bus.scr_data} !== q_m[0]) begin n_fail++; $display("FAIL rnd_head cyc=%0d got=%h exp=%h", i, {bus.scr_addr, bus.scr_data}, q_m[0]); end
      end
      n_checks++;
      if (bus.fifo_overflow !== ovf_m) begin n_fail++; $display("FAIL rnd_overflow cyc=%0d got=%0h exp=%0h", i, bus.fifo_overflow, ovf_m); end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    key_m = 16'h0;
    ovf_m = 1'b0;
    test_reset();
    test_ram();
    test_screen_single();
    test_overflow();
    test_full_push_pop();
    test_keyboard();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
